// File: rtl/gpio_iobuf_bank_if.sv
// Core-side signal bundle for gpio_iobuf_bank: output controls, event controls and input results.
// The core drives through master; the pad bank sits on slave.
interface gpio_iobuf_bank_if #(
  parameter int unsigned WIDTH = 3
);
  logic [WIDTH-1:0] dout;
  logic [WIDTH-1:0] oe;
  logic [WIDTH-1:0] od;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] evt_clr;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] evt;
  logic             irq;

  modport master (
    output dout, oe, od, rise_en, fall_en, evt_clr,
    input  din, rise, fall, evt, irq
  );

  modport slave (
    input  dout, oe, od, rise_en, fall_en, evt_clr,
    output din, rise, fall, evt, irq
  );
endinterface

// File: rtl/gpio_iobuf_bank.sv
// Bank of bidirectional pad slices: registered push-pull/open-drain drive, synchronised and
// debounced input, edge pulses, sticky per-pin event flags and a combined interrupt.
module gpio_iobuf_bank #(
  parameter int unsigned WIDTH       = 3,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEBOUNCE    = 4
) (
  input  logic             clk,
  input  logic             rst,
  inout  wire  [WIDTH-1:0] pad,
  gpio_iobuf_bank_if.slave bus
);
  localparam int unsigned     CntW   = (DEBOUNCE > 0) ? $clog2(DEBOUNCE + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'((DEBOUNCE > 0) ? DEBOUNCE - 1 : 0);

  logic [WIDTH-1:0] dout_q, oe_q, od_q;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [CntW-1:0]  cnt_q [WIDTH];
  logic [CntW-1:0]  cnt_d [WIDTH];
  logic [WIDTH-1:0] din_q, din_d;
  logic [WIDTH-1:0] rise_q, fall_q;
  logic [WIDTH-1:0] evt_q, evt_d;
  logic             irq_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q <= '0;
      oe_q   <= '0;
      od_q   <= '0;
    end else begin
      dout_q <= bus.dout;
      oe_q   <= bus.oe;
      od_q   <= bus.od;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_pad
    // Open-drain with a 1 releases the pin; any other enabled case drives dout_q.
    assign pad[i] = (oe_q[i] && !(od_q[i] && dout_q[i])) ? dout_q[i] : 1'bz;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= pad;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // The counter only advances while sync disagrees with din; any agreement restarts it.
  always_comb begin
    din_d = din_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (DEBOUNCE == 0) begin
        din_d[i] = sync[i];
      end else if (sync[i] != din_q[i]) begin
        if (cnt_q[i] == CntMax) din_d[i] = sync[i];
        else                    cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Set has priority over a coincident clear.
  assign evt_d = (evt_q & ~bus.evt_clr) | (rise_q & bus.rise_en) | (fall_q & bus.fall_en);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      din_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
      evt_q  <= '0;
      irq_q  <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      din_q  <= din_d;
      rise_q <= din_d & ~din_q;
      fall_q <= ~din_d & din_q;
      evt_q  <= evt_d;
      irq_q  <= |evt_q;
    end
  end

  assign bus.din  = din_q;
  assign bus.rise = rise_q;
  assign bus.fall = fall_q;
  assign bus.evt  = evt_q;
  assign bus.irq  = irq_q;
endmodule
